serial_parity_rx: RTL

Serial frame receiver and parity checker: the receiving end of the team's XOR-based serial parity link. It samples one line bit per qualified clock. It deframes start / data / parity / stop. It rebuilds the parallel word and accumulates parity with a running XOR. It flags parity and framing errors. It sits between the serial line (or the matching parity transmitter) and any parallel consumer.

---
 rtl/serial_parity_rx_if.sv | 33 +++
 rtl/serial_parity_rx.sv | 101 ++++++++++
 2 files changed

// File: rtl/serial_parity_rx_if.sv
// Serial-line and parallel-result bundle for serial_parity_rx.
// The slave modport is the receiver side; the master modport is the line driver / consumer side.
interface serial_parity_rx_if #(
    parameter int DATA_W = 8
);
    logic              bit_in;
    logic              bit_vld;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic              par_err;
    logic              frm_err;
    logic              busy;

    modport master (
        output bit_in,
        output bit_vld,
        input  rx_data,
        input  rx_done,
        input  par_err,
        input  frm_err,
        input  busy
    );

    modport slave (
        input  bit_in,
        input  bit_vld,
        output rx_data,
        output rx_done,
        output par_err,
        output frm_err,
        output busy
    );
endinterface

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start / DATA_W data bits (LSB first) / parity / stop, with parity and framing checks.
// Define PARITY_ODD_EN to expect odd parity; the default build expects even parity.
module serial_parity_rx #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_parity_rx_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef PARITY_ODD_EN
    localparam logic PAR_SENSE = 1'b1;
`else
    localparam logic PAR_SENSE = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shift;
    logic              acc;
    logic              par_bad;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_done_q;
    logic              par_err_q;
    logic              frm_err_q;
    logic              busy_q;

    // Widening by one bit keeps the right shift legal even when DATA_W is 1.
    logic [DATA_W:0]   shift_ext;
    assign shift_ext = {bus.bit_in, shift};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            acc       <= 1'b0;
            par_bad   <= 1'b0;
            rx_data_q <= '0;
            rx_done_q <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            if (bus.bit_vld) begin
                case (state)
                    IDLE: begin
                        if (!bus.bit_in) begin
                            shift  <= '0;
                            acc    <= 1'b0;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= DATA;
                        end
                    end
                    DATA: begin
                        shift <= shift_ext[DATA_W:1];
                        acc   <= acc ^ bus.bit_in;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bad <= acc ^ bus.bit_in ^ PAR_SENSE;
                        state   <= STOP;
                    end
                    STOP: begin
                        // A zero stop bit only flags an error; it never doubles as a start bit.
                        rx_data_q <= shift;
                        par_err_q <= par_bad;
                        frm_err_q <= ~bus.bit_in;
                        rx_done_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end
                    default: begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rx_done = rx_done_q;
    assign bus.par_err = par_err_q;
    assign bus.frm_err = frm_err_q;
    assign bus.busy    = busy_q;

endmodule
